// File: rtl/text_buffer.sv
// text_buffer: character screen memory with a hardware cursor.
// Clears of a row or the whole screen run one byte per cycle while busy.
module text_buffer #(
  parameter int COLS = 16,
  parameter int ROWS = 4,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_char,
  input  logic [CW-1:0] rd_col,
  input  logic [RW-1:0] rd_row,
  output logic [7:0]    rd_char,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          busy,
  output logic          wr_ack
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [AW-1:0] CNT_ALL = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CNT_ROW = AW'(COLS - 1);
  localparam logic [7:0]    BLANK   = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic [CW-1:0] col;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row;
  logic [RW-1:0] row_nxt;
  logic [RW-1:0] row_inc;
  logic          ack_nxt;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] rd_addr;

  logic [7:0] mem [DEPTH];

  logic is_print;
  logic is_bs;
  logic is_cr;
  logic is_ff;

  function automatic logic [AW-1:0] addr_of(
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign is_print = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign is_bs    = (wr_char == 8'h08);
  assign is_cr    = (wr_char == 8'h0D);
  assign is_ff    = (wr_char == 8'h0C);

  assign row_inc = (row == ROW_MAX) ? '0 : row + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    row_nxt   = row;
    ack_nxt   = 1'b0;
    we        = 1'b0;
    waddr     = addr_of(row, col);
    wdata     = BLANK;
    unique case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == CNT_ALL) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CLEAR_ROW: begin
        // row already points at the freshly entered line
        we    = 1'b1;
        waddr = addr_of(row, CW'(cnt));
        if (cnt == CNT_ROW) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (wr_en) begin
          unique case (1'b1)
            is_print: begin
              ack_nxt = 1'b1;
              we      = 1'b1;
              waddr   = addr_of(row, col);
              wdata   = wr_char;
              if (col == COL_MAX) begin
                col_nxt   = '0;
                row_nxt   = row_inc;
                state_nxt = CLEAR_ROW;
                cnt_nxt   = '0;
              end else begin
                col_nxt = col + 1'b1;
              end
            end
            is_bs: begin
              ack_nxt = 1'b1;
              if (col != '0) begin
                col_nxt = col - 1'b1;
                we      = 1'b1;
                waddr   = addr_of(row, col - 1'b1);
              end else if (row != '0) begin
                col_nxt = COL_MAX;
                row_nxt = row - 1'b1;
                we      = 1'b1;
                waddr   = addr_of(row - 1'b1, COL_MAX);
              end
            end
            is_cr: begin
              ack_nxt   = 1'b1;
              col_nxt   = '0;
              row_nxt   = row_inc;
              state_nxt = CLEAR_ROW;
              cnt_nxt   = '0;
            end
            is_ff: begin
              ack_nxt   = 1'b1;
              col_nxt   = '0;
              row_nxt   = '0;
              state_nxt = CLEAR_ALL;
              cnt_nxt   = '0;
            end
            default: ;
          endcase
        end
      end
      default: begin
        state_nxt = CLEAR_ALL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= CLEAR_ALL;
      cnt    <= '0;
      col    <= '0;
      row    <= '0;
      wr_ack <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      wr_ack <= ack_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_addr = addr_of(rd_row, rd_col);

  // NBA ordering gives read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_char <= 8'h00;
    end else begin
      rd_char <= mem[rd_addr];
    end
  end

  assign busy       = (state != IDLE);
  assign cursor_col = col;
  assign cursor_row = row;

endmodule
